// File: rtl/max_pool_2x2.sv
// Streaming 2x2, stride-2 signed max-pool using a half-width line buffer.
// Optional: define MAXPOOL_ARGMAX_EN to add out_idx (window position of the winner).
module max_pool_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 24,
  parameter int IMG_HEIGHT = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef MAXPOOL_ARGMAX_EN
  ,
  output logic [1:0]            out_idx
`endif
);

  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int COL_W    = (IMG_WIDTH > 1)  ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_AW    = (LB_DEPTH > 1)   ? $clog2(LB_DEPTH)   : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             r_row;
  logic signed [DATA_WIDTH-1:0] r_h_max;
  logic signed [DATA_WIDTH-1:0] r_linebuf [LB_DEPTH];
  logic [DATA_WIDTH-1:0]        r_out_data;
  logic                         r_out_valid;
  logic                         r_out_last;

  logic                         w_accept;
  logic                         w_col_odd;
  logic                         w_row_odd;
  logic                         w_col_end;
  logic                         w_row_end;
  logic                         w_top_write;
  logic                         w_win_done;
  logic [LB_AW-1:0]             w_lb_addr;
  logic signed [DATA_WIDTH-1:0] w_pix;
  logic signed [DATA_WIDTH-1:0] w_pair_max;
  logic signed [DATA_WIDTH-1:0] w_lb_rd;
  logic signed [DATA_WIDTH-1:0] w_win_max;
  logic                         w_pair_right;
  logic                         w_bot_wins;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  assign w_col_odd = r_col[0];
  assign w_row_odd = r_row[0];
  assign w_col_end = (r_col == COL_LAST);
  assign w_row_end = (r_row == ROW_LAST);
  assign w_lb_addr = LB_AW'(r_col >> 1);

  assign w_top_write = w_accept && w_col_odd && !w_row_odd;
  assign w_win_done  = w_accept && w_col_odd && w_row_odd;

  // Strict greater-than everywhere: on a tie the earlier pixel in raster order wins.
  assign w_pix        = in_data;
  assign w_pair_right = (w_pix > r_h_max);
  assign w_pair_max   = w_pair_right ? w_pix : r_h_max;
  assign w_lb_rd      = r_linebuf[w_lb_addr];
  assign w_bot_wins   = (w_pair_max > w_lb_rd);
  assign w_win_max    = w_bot_wins ? w_pair_max : w_lb_rd;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_h_max <= '0;
    end else if (w_accept) begin
      if (!w_col_odd) begin
        r_h_max <= w_pix;
      end
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // NOTE: the line buffer has no reset; each entry is written on a top row before the
  // bottom row reads it, and leaving reset off lets it map onto a RAM.
  always_ff @(posedge clk) begin
    if (w_top_write) begin
      r_linebuf[w_lb_addr] <= w_pair_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_win_done) begin
      r_out_data  <= w_win_max;
      r_out_valid <= 1'b1;
      r_out_last  <= w_col_end && w_row_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

`ifdef MAXPOOL_ARGMAX_EN
  // The h_max stage always starts on the left pixel, so its index is just the compare result.
  logic       r_lb_idx [LB_DEPTH];
  logic [1:0] r_out_idx;

  always_ff @(posedge clk) begin
    if (w_top_write) begin
      r_lb_idx[w_lb_addr] <= w_pair_right;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_idx <= 2'd0;
    end else if (w_win_done) begin
      r_out_idx <= w_bot_wins ? {1'b1, w_pair_right} : {1'b0, r_lb_idx[w_lb_addr]};
    end
  end

  assign out_idx = r_out_idx;
`endif

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: a 4x4 instance for directed windows and
// a 24x24 instance for full-size random frames, checked against a window-max model.
module tb_max_pool_2x2;

  localparam int DW = 16;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int BW = 24;
  localparam int BH = 24;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    idx;
  } exp_t;

  typedef struct packed {
    logic [3:0][DW-1:0] win;
    logic [DW-1:0]      exp_max;
    logic [1:0]         exp_idx;
  } vec_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          sel       = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_last;
  logic [DW-1:0] s_out_data;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_last;
  logic [DW-1:0] b_out_data;
  logic          m_in_ready, m_out_valid, m_out_last;
  logic [DW-1:0] m_out_data;
`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0]    s_out_idx, b_out_idx, m_out_idx;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   n_last  = 0;
  exp_t exp_q[$];
  logic [DW-1:0] frame [BW*BH];
  vec_t vecs [10];

  always #5 clk = ~clk;

  assign s_in_valid  = in_valid && !sel;
  assign b_in_valid  = in_valid && sel;
  assign m_in_ready  = sel ? b_in_ready  : s_in_ready;
  assign m_out_valid = sel ? b_out_valid : s_out_valid;
  assign m_out_last  = sel ? b_out_last  : s_out_last;
  assign m_out_data  = sel ? b_out_data  : s_out_data;
`ifdef MAXPOOL_ARGMAX_EN
  assign m_out_idx   = sel ? b_out_idx   : s_out_idx;
`endif

  max_pool_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) u_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_last(s_out_last)
`ifdef MAXPOOL_ARGMAX_EN
    , .out_idx(s_out_idx)
`endif
  );

  max_pool_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) u_big (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_last(b_out_last)
`ifdef MAXPOOL_ARGMAX_EN
    , .out_idx(b_out_idx)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] c, input logic [DW-1:0] d,
                              input logic [DW-1:0] m, input logic [1:0] i);
    vec_t v;
    v.win[0]  = a;
    v.win[1]  = b;
    v.win[2]  = c;
    v.win[3]  = d;
    v.exp_max = m;
    v.exp_idx = i;
    return v;
  endfunction

  function automatic logic is_br(input int k);
    return (((k / SW) % 2) == 1) && (((k % SW) % 2) == 1);
  endfunction

  task automatic push_hand(input logic [DW-1:0] d, input logic last, input logic [1:0] idx);
    exp_t e;
    e.data = d;
    e.last = last;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Reference: scan the four window pixels in raster order, replace only on strictly greater.
  task automatic push_model(input int w, input int h, input int n_beats);
    logic [DW-1:0] v [4];
    int            best;
    int            br;
    exp_t          e;
    for (int r = 0; r < h; r += 2) begin
      for (int c = 0; c < w; c += 2) begin
        v[0] = frame[r*w + c];
        v[1] = frame[r*w + c + 1];
        v[2] = frame[(r+1)*w + c];
        v[3] = frame[(r+1)*w + c + 1];
        best = 0;
        for (int i = 1; i < 4; i++) begin
          if ($signed(v[i]) > $signed(v[best])) best = i;
        end
        br = (r+1)*w + c + 1;
        if (br < n_beats) begin
          e.data = v[best];
          e.last = (br == w*h - 1);
          e.idx  = best[1:0];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic send(input int first, input int stop, input int p_valid, input int p_ready);
    int k;
    int cyc;
    k   = first;
    cyc = 0;
    while (k < stop && cyc < 20000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(99) < p_valid);
      in_data   = frame[k];
      out_ready = ($urandom_range(99) < p_ready);
      #1;
      if (in_valid && m_in_ready) k++;
      cyc++;
    end
    if (k < stop) check("send_timeout", k, stop);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic drain();
    int cyc;
    cyc       = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    check("drain_idle_valid", m_out_valid, 1'b0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < SW*SH; i++) frame[i] = DW'(i + 1);
  endtask

  task automatic push_ramp_expect();
    push_hand(16'd6,  1'b0, 2'd3);
    push_hand(16'd8,  1'b0, 2'd3);
    push_hand(16'd14, 1'b0, 2'd3);
    push_hand(16'd16, 1'b1, 2'd3);
  endtask

  // Scoreboard: every consumed beat must match the head of the expected queue.
  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (!rst && m_out_valid && out_ready) begin
      n_out++;
      if (m_out_last) n_last++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, want no output", m_out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", m_out_data, e.data);
        check("out_last", m_out_last, e.last);
`ifdef MAXPOOL_ARGMAX_EN
        check("out_idx", m_out_idx, e.idx);
`endif
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = mk(16'hFFFB, 16'hFFFD, 16'hFFF9, 16'hFFFE, 16'hFFFE, 2'd3);
    vecs[1] = mk(16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF, 2'd0);
    vecs[2] = mk(16'd9, 16'd1, 16'd1, 16'd1, 16'd9, 2'd0);
    vecs[3] = mk(16'd1, 16'd9, 16'd1, 16'd1, 16'd9, 2'd1);
    vecs[4] = mk(16'd1, 16'd1, 16'd9, 16'd1, 16'd9, 2'd2);
    vecs[5] = mk(16'd1, 16'd1, 16'd1, 16'd9, 16'd9, 2'd3);
    vecs[6] = mk(16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 2'd0);
    vecs[7] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 2'd0);
    vecs[8] = mk(16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 2'd1);
    vecs[9] = mk(16'd3, 16'd7, 16'd7, 16'd2, 16'd7, 2'd1);

    // Reset state of both instances
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_out_valid", m_out_valid, 1'b0);
      check("rst_out_data", m_out_data, 16'd0);
      check("rst_out_last", m_out_last, 1'b0);
      check("rst_in_ready", m_in_ready, 1'b1);
`ifdef MAXPOOL_ARGMAX_EN
      check("rst_out_idx", m_out_idx, 2'd0);
`endif
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 4x4 ramp: out_valid exactly one cycle after each bottom-right beat
    load_ramp();
    push_ramp_expect();
    for (int k = 0; k < SW*SH; k++) begin
      @(negedge clk);
      #1;
      if (k > 0) check("latency_valid", m_out_valid, is_br(k - 1));
      in_valid  = 1'b1;
      in_data   = frame[k];
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("latency_valid_last", m_out_valid, 1'b1);
    drain();

    // Table-driven windows, each tiled across all four windows of a 4x4 frame
    for (int v = 0; v < 10; v++) begin
      for (int r = 0; r < SH; r++) begin
        for (int c = 0; c < SW; c++) frame[r*SW + c] = vecs[v].win[(r % 2)*2 + (c % 2)];
      end
      for (int j = 0; j < 4; j++) push_hand(vecs[v].exp_max, (j == 3), vecs[v].exp_idx);
      send(0, SW*SH, 100, 100);
      drain();
    end

    // Back-pressure: hold the first result for 5 cycles with a beat waiting
    load_ramp();
    push_ramp_expect();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = frame[k];
      out_ready = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = frame[6];
      out_ready = 1'b0;
      #1;
      check("bp_in_ready", m_in_ready, 1'b0);
      check("bp_out_valid", m_out_valid, 1'b1);
      check("bp_out_data", m_out_data, 16'd6);
      check("bp_out_last", m_out_last, 1'b0);
    end
    send(6, SW*SH, 100, 100);
    drain();

    // Reset after 30 beats (one full frame plus 14), then a clean frame
    load_ramp();
    push_ramp_expect();
    send(0, SW*SH, 100, 100);
    push_hand(16'd6,  1'b0, 2'd3);
    push_hand(16'd8,  1'b0, 2'd3);
    push_hand(16'd14, 1'b0, 2'd3);
    send(0, 14, 100, 100);
    drain();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", m_out_valid, 1'b0);
    push_ramp_expect();
    send(0, SW*SH, 100, 100);
    drain();

    // Full 24x24 random frame at full rate
    sel    = 1'b1;
    n_out  = 0;
    n_last = 0;
    for (int i = 0; i < BW*BH; i++) frame[i] = DW'($urandom);
    push_model(BW, BH, BW*BH);
    send(0, BW*BH, 100, 100);
    drain();
    check("big_out_count", n_out, 144);
    check("big_last_count", n_last, 1);

    // Three 24x24 frames with random input gaps and random back-pressure
    n_out  = 0;
    n_last = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < BW*BH; i++) frame[i] = DW'($urandom);
      push_model(BW, BH, BW*BH);
      send(0, BW*BH, 50, 50);
    end
    drain();
    check("rand_out_count", n_out, 432);
    check("rand_last_count", n_last, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
